// File: rtl/pio_mc_mem_if.sv
// PIO register bus plus application read/write channels of pio_mc_mem.
// The master drives requests and addresses; the slave (memory) returns acks, grants and data.
`ifndef PIO_NBITS
`define PIO_NBITS 32
`endif

interface pio_mc_mem_if #(
    parameter int WIDTH       = 64,
    parameter int DEPTH_NBITS = 10,
    parameter int NUM_RD      = 2
);
    logic                          clk_div;
    logic [`PIO_NBITS-1:0]         reg_addr;
    logic [`PIO_NBITS-1:0]         reg_din;
    logic                          reg_rd;
    logic                          reg_wr;
    logic                          reg_ms;
    logic                          mem_ack;
    logic [`PIO_NBITS-1:0]         mem_rdata;
    logic [NUM_RD-1:0]             app_rd_req;
    logic [NUM_RD*DEPTH_NBITS-1:0] app_rd_addr;
    logic [NUM_RD-1:0]             app_rd_gnt;
    logic [NUM_RD-1:0]             app_rd_ack;
    logic [WIDTH-1:0]              app_rd_data;
    logic                          app_wr;
    logic [DEPTH_NBITS-1:0]        app_wr_addr;
    logic [WIDTH-1:0]              app_wr_data;

    modport master (
        output clk_div, reg_addr, reg_din, reg_rd, reg_wr, reg_ms,
        output app_rd_req, app_rd_addr, app_wr, app_wr_addr, app_wr_data,
        input  mem_ack, mem_rdata, app_rd_gnt, app_rd_ack, app_rd_data
    );

    modport slave (
        input  clk_div, reg_addr, reg_din, reg_rd, reg_wr, reg_ms,
        input  app_rd_req, app_rd_addr, app_wr, app_wr_addr, app_wr_data,
        output mem_ack, mem_rdata, app_rd_gnt, app_rd_ack, app_rd_data
    );
endinterface

// File: rtl/pio_mc_mem.sv
// Wide PIO-accessible RAM shared by NUM_RD round-robin app read channels, one app writer and host PIO.
// Latency: app/PIO read data registered 2 cycles after grant; PIO writes complete on the cycle the RAM port is free.
// Backpressure: app reads wait for a combinational grant; app writes never stall; a starved PIO read preempts after PIO_MAX_WAIT.
`ifndef PIO_NBITS
`define PIO_NBITS 32
`endif

module pio_mc_mem #(
    parameter int WIDTH        = 64,
    parameter int DEPTH_NBITS  = 10,
    parameter int NUM_RD       = 2,
    parameter bit REG_WR_EN    = 1'b1,
    parameter int PIO_MAX_WAIT = 8
) (
    input  logic         clk,
    input  logic         rst,
    pio_mc_mem_if.slave  bus
);
    localparam int PW         = `PIO_NBITS;
    localparam int LANES      = (WIDTH + PW - 1) / PW;
    localparam int LANE_SHIFT = (LANES > 1) ? $clog2(LANES) : 0;
    localparam int LANE_NBITS = (LANE_SHIFT > 0) ? LANE_SHIFT : 1;
    localparam int EXT_W      = LANES * PW;
    localparam int BYTE_SHIFT = $clog2(PW / 8);
    localparam int WAIT_NBITS = $clog2(PIO_MAX_WAIT + 1);
    localparam int RR_NBITS   = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
    localparam logic [WAIT_NBITS-1:0] WAIT_MAX  = WAIT_NBITS'(PIO_MAX_WAIT);
    localparam logic [LANE_NBITS:0]   LANES_W   = (LANE_NBITS + 1)'(LANES);
    localparam logic [LANE_NBITS-1:0] LAST_LANE = LANE_NBITS'(LANES - 1);
    localparam logic [RR_NBITS-1:0]   LAST_CH   = RR_NBITS'(NUM_RD - 1);

    logic [WIDTH-1:0]       mem [2**DEPTH_NBITS];
    logic [WIDTH-1:0]       ram_q;
    logic [EXT_W-1:0]       ram_ext;

    logic [PW-1:0]          dword;
    logic [LANE_NBITS-1:0]  lane;
    logic [DEPTH_NBITS-1:0] entry;
    logic                   lane_ok;

    logic [PW-1:0]          stage_dat [LANES];
    logic [LANES-1:0]       stage_vld;
    logic [EXT_W-1:0]       commit_ext;
    logic [WIDTH-1:0]       new_entry;

    logic                   rd_pend, wr_pend, done, s1_pio, s1_lane_ok, rd_lane_ok;
    logic [WAIT_NBITS-1:0]  wait_cnt;
    logic [DEPTH_NBITS-1:0] rd_entry, wr_addr_q;
    logic [LANE_NBITS-1:0]  rd_lane, s1_lane;
    logic [WIDTH-1:0]       wr_ent;
    logic [NUM_RD-1:0]      s1_app;

    logic [NUM_RD-1:0]      rr_gnt;
    logic [RR_NBITS-1:0]    rr_ptr, rr_idx, rr_cand;

    logic pio_idle, wr_strobe, rd_strobe, wr_last, wr_stage;
    logic pio_commit_req, pio_commit_go, done_set;
    logic urgent, app_any, app_gnt_en, pio_serve;
    logic ram_we;
    logic [DEPTH_NBITS-1:0] ram_wa, ram_ra;
    logic [WIDTH-1:0]       ram_wd;

    // Byte address -> dword -> {entry, lane}
    assign dword   = bus.reg_addr >> BYTE_SHIFT;
    assign lane    = LANE_NBITS'(dword & PW'((1 << LANE_SHIFT) - 1));
    assign entry   = DEPTH_NBITS'(dword >> LANE_SHIFT);
    assign lane_ok = {1'b0, lane} < LANES_W;

    // A new PIO access is only accepted once the previous one has fully acked.
    assign pio_idle  = !rst && !rd_pend && !wr_pend && !s1_pio && !done && !bus.mem_ack;
    assign wr_strobe = pio_idle && bus.reg_ms && bus.reg_wr;
    assign rd_strobe = pio_idle && bus.reg_ms && bus.reg_rd && !bus.reg_wr;
    assign wr_last   = wr_strobe && REG_WR_EN && lane_ok && (lane == LAST_LANE);
    assign wr_stage  = wr_strobe && REG_WR_EN && lane_ok && (lane != LAST_LANE);

    always_comb begin
        commit_ext = '0;
        for (int i = 0; i < LANES - 1; i++)
            commit_ext[i*PW +: PW] = stage_vld[i] ? stage_dat[i] : '0;
        commit_ext[(LANES-1)*PW +: PW] = bus.reg_din;
    end
    assign new_entry = commit_ext[WIDTH-1:0];

    // Write port: app writer first, PIO commit retried until the port is free.
    assign pio_commit_req = !rst && (wr_pend || wr_last);
    assign pio_commit_go  = pio_commit_req && !bus.app_wr;
    assign ram_we = bus.app_wr || pio_commit_req;
    assign ram_wa = bus.app_wr ? bus.app_wr_addr : (wr_pend ? wr_addr_q : entry);
    assign ram_wd = bus.app_wr ? bus.app_wr_data : (wr_pend ? wr_ent : new_entry);

    // Round-robin search starting at rr_ptr; lowest offset wins.
    always_comb begin
        rr_gnt  = '0;
        rr_idx  = rr_ptr;
        rr_cand = rr_ptr;
        for (int k = NUM_RD - 1; k >= 0; k--) begin
            rr_cand = RR_NBITS'((int'(rr_ptr) + k) % NUM_RD);
            if (bus.app_rd_req[rr_cand]) begin
                rr_gnt          = '0;
                rr_gnt[rr_cand] = 1'b1;
                rr_idx          = rr_cand;
            end
        end
    end

    assign urgent         = rd_pend && (wait_cnt == WAIT_MAX);
    assign app_any        = |bus.app_rd_req;
    assign app_gnt_en     = !rst && !urgent && app_any;
    assign pio_serve      = !rst && rd_pend && (urgent || !app_any);
    assign bus.app_rd_gnt = app_gnt_en ? rr_gnt : '0;
    assign ram_ra         = pio_serve ? rd_entry : bus.app_rd_addr[rr_idx*DEPTH_NBITS +: DEPTH_NBITS];
    assign ram_ext        = EXT_W'(ram_q);
    assign done_set       = pio_commit_go || (wr_strobe && !wr_last) || s1_pio;

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.mem_ack    <= 1'b0;
            bus.app_rd_ack <= '0;
            rr_ptr         <= '0;
            rd_pend        <= 1'b0;
            wr_pend        <= 1'b0;
            wait_cnt       <= '0;
            stage_vld      <= '0;
            done           <= 1'b0;
            s1_app         <= '0;
            s1_pio         <= 1'b0;
        end else begin
            if (app_gnt_en)
                rr_ptr <= (rr_idx == LAST_CH) ? '0 : rr_idx + 1'b1;

            if (rd_strobe)
                rd_pend <= 1'b1;
            else if (pio_serve)
                rd_pend <= 1'b0;

            if (pio_serve)
                wait_cnt <= '0;
            else if (rd_pend && wait_cnt != WAIT_MAX)
                wait_cnt <= wait_cnt + 1'b1;

            if (wr_last && bus.app_wr)
                wr_pend <= 1'b1;
            else if (pio_commit_go)
                wr_pend <= 1'b0;

            if (wr_stage)
                stage_vld[lane] <= 1'b1;

            s1_app         <= bus.app_rd_gnt;
            s1_pio         <= pio_serve;
            bus.app_rd_ack <= s1_app;

            // Ack rises on a clk_div cycle and is held until the next one.
            if (done && !bus.mem_ack && bus.clk_div) begin
                bus.mem_ack <= 1'b1;
                done        <= 1'b0;
            end else if (bus.mem_ack && bus.clk_div) begin
                bus.mem_ack <= 1'b0;
            end
            if (done_set)
                done <= 1'b1;
        end
    end

    // Read-first RAM and unreset data path.
    always_ff @(posedge clk) begin
        if (ram_we)
            mem[ram_wa] <= ram_wd;
        ram_q <= mem[ram_ra];

        if (wr_stage)
            stage_dat[lane] <= bus.reg_din;
        if (wr_last && bus.app_wr) begin
            wr_ent    <= new_entry;
            wr_addr_q <= entry;
        end
        if (rd_strobe) begin
            rd_entry   <= entry;
            rd_lane    <= lane;
            rd_lane_ok <= lane_ok;
        end
        if (pio_serve) begin
            s1_lane    <= rd_lane;
            s1_lane_ok <= rd_lane_ok;
        end
        if (|s1_app)
            bus.app_rd_data <= ram_q;
        if (s1_pio)
            bus.mem_rdata <= s1_lane_ok ? ram_ext[s1_lane*PW +: PW] : '0;
    end
endmodule

// File: tb/tb_pio_mc_mem.sv
// Directed bench for pio_mc_mem: two instances (PIO writes enabled / disabled) share one stimulus stream.
module tb_pio_mc_mem;
    localparam int WIDTH = 64;
    localparam int DN    = 10;
    localparam int NR    = 2;

    logic clk       = 1'b0;
    logic rst       = 1'b1;
    logic clk_div_r = 1'b0;
    int   n_chk     = 0;
    int   n_bad     = 0;
    int   ack_cnt0  = 0;
    int   ack_cnt1  = 0;
    logic ack_prev0 = 1'b0;
    logic ack_prev1 = 1'b0;

    pio_mc_mem_if #(.WIDTH(WIDTH), .DEPTH_NBITS(DN), .NUM_RD(NR)) ifc0();
    pio_mc_mem_if #(.WIDTH(WIDTH), .DEPTH_NBITS(DN), .NUM_RD(NR)) ifc1();

    pio_mc_mem #(.WIDTH(WIDTH), .DEPTH_NBITS(DN), .NUM_RD(NR), .REG_WR_EN(1'b1), .PIO_MAX_WAIT(8))
        u_dut (.clk(clk), .rst(rst), .bus(ifc0));
    pio_mc_mem #(.WIDTH(WIDTH), .DEPTH_NBITS(DN), .NUM_RD(NR), .REG_WR_EN(1'b0), .PIO_MAX_WAIT(8))
        u_dut_nowr (.clk(clk), .rst(rst), .bus(ifc1));

    always #5 clk = ~clk;
    always @(posedge clk) clk_div_r <= ~clk_div_r;

    assign ifc0.clk_div     = clk_div_r;
    assign ifc1.clk_div     = clk_div_r;
    assign ifc1.reg_addr    = ifc0.reg_addr;
    assign ifc1.reg_din     = ifc0.reg_din;
    assign ifc1.reg_rd      = ifc0.reg_rd;
    assign ifc1.reg_wr      = ifc0.reg_wr;
    assign ifc1.reg_ms      = ifc0.reg_ms;
    assign ifc1.app_rd_req  = ifc0.app_rd_req;
    assign ifc1.app_rd_addr = ifc0.app_rd_addr;
    assign ifc1.app_wr      = ifc0.app_wr;
    assign ifc1.app_wr_addr = ifc0.app_wr_addr;
    assign ifc1.app_wr_data = ifc0.app_wr_data;

    // Count mem_ack rising edges so pulses are never missed by the stimulus thread.
    always @(negedge clk) begin
        if (ifc0.mem_ack && !ack_prev0) ack_cnt0++;
        if (ifc1.mem_ack && !ack_prev1) ack_cnt1++;
        ack_prev0 = ifc0.mem_ack;
        ack_prev1 = ifc1.mem_ack;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input int c0, input string tag);
        int n;
        n = 0;
        while (ack_cnt0 == c0 && n < 40) begin
            tick();
            n++;
        end
        chk(tag, 64'(ack_cnt0 != c0), 64'd1);
        repeat (4) tick();
    endtask

    task automatic pio_wr(input logic [31:0] addr, input logic [31:0] d, input string tag);
        int c0;
        c0 = ack_cnt0;
        ifc0.reg_addr = addr;
        ifc0.reg_din  = d;
        ifc0.reg_ms   = 1'b1;
        ifc0.reg_wr   = 1'b1;
        tick();
        ifc0.reg_ms   = 1'b0;
        ifc0.reg_wr   = 1'b0;
        wait_ack(c0, tag);
    endtask

    task automatic pio_rd(input logic [31:0] addr, output logic [31:0] d, input string tag);
        int c0;
        c0 = ack_cnt0;
        ifc0.reg_addr = addr;
        ifc0.reg_ms   = 1'b1;
        ifc0.reg_rd   = 1'b1;
        tick();
        ifc0.reg_ms   = 1'b0;
        ifc0.reg_rd   = 1'b0;
        wait_ack(c0, tag);
        d = ifc0.mem_rdata;
    endtask

    task automatic app_read(input int ch, input logic [DN-1:0] a, output logic [63:0] d0,
                            output logic [63:0] d1, input string tag);
        int n;
        n = 0;
        ifc0.app_rd_addr[ch*DN +: DN] = a;
        ifc0.app_rd_req[ch] = 1'b1;
        #1;
        while (!ifc0.app_rd_gnt[ch] && n < 40) begin
            tick();
            #1;
            n++;
        end
        chk({tag, "_gnt"}, 64'(ifc0.app_rd_gnt), 64'(1) << ch);
        tick();
        ifc0.app_rd_req[ch] = 1'b0;
        tick();
        #1;
        chk({tag, "_ack"}, 64'(ifc0.app_rd_ack), 64'(1) << ch);
        d0 = ifc0.app_rd_data;
        d1 = ifc1.app_rd_data;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        n_bad++;
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] d0, d1;
        logic [31:0] r;
        logic [1:0]  exp_g [8];
        logic [1:0]  exp_a [8];
        int          n, c0, c1;

        ifc0.reg_addr = '0; ifc0.reg_din = '0;
        ifc0.reg_rd = 1'b0; ifc0.reg_wr = 1'b0; ifc0.reg_ms = 1'b0;
        ifc0.app_rd_req = 2'b11; ifc0.app_rd_addr = '0;
        ifc0.app_wr = 1'b0; ifc0.app_wr_addr = '0; ifc0.app_wr_data = '0;

        // Reset: outputs low, grants suppressed even with requests present.
        rst = 1'b1;
        repeat (3) tick();
        #1;
        chk("rst_mem_ack", 64'(ifc0.mem_ack), 64'd0);
        chk("rst_rd_ack",  64'(ifc0.app_rd_ack), 64'd0);
        chk("rst_gnt",     64'(ifc0.app_rd_gnt), 64'd0);
        ifc0.app_rd_req = 2'b00;
        rst = 1'b0;
        tick();

        // Two-lane PIO write to entry 5, then app and PIO readback.
        pio_wr(32'd40, 32'h1111_1111, "w5l0_ack");
        pio_wr(32'd44, 32'h2222_2222, "w5l1_ack");
        app_read(0, 10'd5, d0, d1, "rd5");
        chk("rd5_dat", d0, 64'h2222_2222_1111_1111);
        pio_rd(32'd40, r, "prd5l0_ack");
        chk("prd5l0_dat", 64'(r), 64'h1111_1111);

        // Round-robin from a fresh pointer: grants alternate, acks trail by two cycles.
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00};
        exp_a = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        ifc0.app_rd_addr = {10'd5, 10'd5};
        for (int i = 0; i < 8; i++) begin
            ifc0.app_rd_req = (i < 6) ? 2'b11 : 2'b00;
            #1;
            chk($sformatf("rr_gnt%0d", i), 64'(ifc0.app_rd_gnt), 64'(exp_g[i]));
            chk($sformatf("rr_ack%0d", i), 64'(ifc0.app_rd_ack), 64'(exp_a[i]));
            tick();
        end

        // Saturated app traffic: PIO read of entry 5 lane 1 waits exactly 8 granted cycles.
        c0 = ack_cnt0;
        ifc0.app_rd_req = 2'b11;
        ifc0.reg_addr = 32'd44;
        ifc0.reg_ms = 1'b1;
        ifc0.reg_rd = 1'b1;
        tick();
        ifc0.reg_ms = 1'b0;
        ifc0.reg_rd = 1'b0;
        n = 0;
        #1;
        while (ifc0.app_rd_gnt != 2'b00 && n < 30) begin
            n++;
            tick();
            #1;
        end
        chk("starve_cycles", 64'(n), 64'd8);
        chk("starve_pio_owns_port", 64'(ifc0.app_rd_gnt), 64'd0);
        tick();
        ifc0.app_rd_req = 2'b00;
        wait_ack(c0, "starve_ack");
        chk("starve_rdata", 64'(ifc0.mem_rdata), 64'h2222_2222);

        // Last-lane PIO write collides with app_wr to entry 3.
        pio_wr(32'd24, 32'h3333_3333, "w3l0_ack");
        c0 = ack_cnt0;
        ifc0.reg_addr = 32'd28;
        ifc0.reg_din = 32'h4444_4444;
        ifc0.reg_ms = 1'b1;
        ifc0.reg_wr = 1'b1;
        ifc0.app_wr = 1'b1;
        ifc0.app_wr_addr = 10'd3;
        ifc0.app_wr_data = 64'hAAAA_AAAA_BBBB_BBBB;
        tick();
        ifc0.reg_ms = 1'b0;
        ifc0.reg_wr = 1'b0;
        ifc0.app_wr = 1'b0;
        ifc0.app_rd_addr[DN-1:0] = 10'd3;
        ifc0.app_rd_req = 2'b01;
        #1;
        chk("coll_gnt", 64'(ifc0.app_rd_gnt), 64'd1);
        tick();
        ifc0.app_rd_req = 2'b00;
        tick();
        #1;
        chk("coll_ack", 64'(ifc0.app_rd_ack), 64'd1);
        chk("coll_old_dat", ifc0.app_rd_data, 64'hAAAA_AAAA_BBBB_BBBB);
        wait_ack(c0, "w3l1_ack");
        app_read(0, 10'd3, d0, d1, "rd3");
        chk("rd3_dat", d0, 64'h4444_4444_3333_3333);

        // Write-disabled instance acks PIO writes but keeps app-written contents.
        ifc0.app_wr = 1'b1;
        ifc0.app_wr_addr = 10'd2;
        ifc0.app_wr_data = 64'h0123_4567_89AB_CDEF;
        tick();
        ifc0.app_wr = 1'b0;
        c1 = ack_cnt1;
        pio_wr(32'd16, 32'hDEAD_BEEF, "w2l0_ack");
        pio_wr(32'd20, 32'hDEAD_BEEF, "w2l1_ack");
        chk("nowr_acks", 64'(ack_cnt1 - c1), 64'd2);
        app_read(0, 10'd2, d0, d1, "rd2");
        chk("wr_en_dat", d0, 64'hDEAD_BEEF_DEAD_BEEF);
        chk("nowr_dat", d1, 64'h0123_4567_89AB_CDEF);

        // Reset right after staging lane 0: no ack afterwards, lane 1 still commits.
        c0 = ack_cnt0;
        ifc0.reg_addr = 32'd56;
        ifc0.reg_din = 32'h5555_5555;
        ifc0.reg_ms = 1'b1;
        ifc0.reg_wr = 1'b1;
        tick();
        ifc0.reg_ms = 1'b0;
        ifc0.reg_wr = 1'b0;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (10) tick();
        chk("no_stale_ack", 64'(ack_cnt0 - c0), 64'd0);
        pio_wr(32'd60, 32'h6666_6666, "w7l1_ack");
        app_read(0, 10'd7, d0, d1, "rd7");
        chk("rd7_hi", d0 & 64'hFFFF_FFFF_0000_0000, 64'h6666_6666_0000_0000);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
